// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX register feeding the ALU with forwarding, immediate select and load-use stall
module alu_operand_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR_W    = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_rs1_data,
    input  logic [DATA_WIDTH-1:0]    in_rs2_data,
    input  logic [DATA_WIDTH-1:0]    in_imm,
    input  logic [REG_ADDR_W-1:0]    in_rs1,
    input  logic [REG_ADDR_W-1:0]    in_rs2,
    input  logic [REG_ADDR_W-1:0]    in_rd,
    input  logic                     in_alu_src,
    input  logic [OPCODE_LENGTH-1:0] in_operation,
    input  logic                     in_reg_write,
    input  logic                     in_mem_read,
    input  logic                     flush,
    input  logic [REG_ADDR_W-1:0]    exmem_rd,
    input  logic                     exmem_reg_write,
    input  logic [DATA_WIDTH-1:0]    exmem_result,
    input  logic [REG_ADDR_W-1:0]    memwb_rd,
    input  logic                     memwb_reg_write,
    input  logic [DATA_WIDTH-1:0]    memwb_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    out_store_data,
    output logic [REG_ADDR_W-1:0]    out_rd,
    output logic                     out_reg_write,
    output logic                     out_mem_read
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0]    rs1_data;
        logic [DATA_WIDTH-1:0]    rs2_data;
        logic [DATA_WIDTH-1:0]    imm;
        logic [REG_ADDR_W-1:0]    rs1;
        logic [REG_ADDR_W-1:0]    rs2;
        logic [REG_ADDR_W-1:0]    rd;
        logic                     alu_src;
        logic [OPCODE_LENGTH-1:0] operation;
        logic                     reg_write;
        logic                     mem_read;
    } held_t;

    held_t h, n;
    logic hazard;
    logic [DATA_WIDTH-1:0] fwd_a, fwd_b;

    assign n = '{in_rs1_data, in_rs2_data, in_imm, in_rs1, in_rs2, in_rd,
                 in_alu_src, in_operation, in_reg_write, in_mem_read};

    assign hazard = out_valid && h.mem_read && h.rd != '0 && (h.rd == in_rs1 || h.rd == in_rs2);
    assign in_ready = (!out_valid || out_ready) && !hazard;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_valid <= 1'b0;
            h <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            h <= n;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end

    // EX/MEM is the younger producer, so it wins over MEM/WB; x0 is never forwarded
    always_comb begin
        fwd_a = exmem_reg_write && exmem_rd != '0 && exmem_rd == h.rs1 ? exmem_result :
                memwb_reg_write && memwb_rd != '0 && memwb_rd == h.rs1 ? memwb_result : h.rs1_data;
        fwd_b = exmem_reg_write && exmem_rd != '0 && exmem_rd == h.rs2 ? exmem_result :
                memwb_reg_write && memwb_rd != '0 && memwb_rd == h.rs2 ? memwb_result : h.rs2_data;
    end

    assign SrcA           = fwd_a;
    assign SrcB           = h.alu_src ? h.imm : fwd_b;
    assign Operation      = h.operation;
    assign out_store_data = fwd_b;
    assign out_rd         = h.rd;
    assign out_reg_write  = out_valid && h.reg_write;
    assign out_mem_read   = out_valid && h.mem_read;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed and random checks against a behavioural model of the stage
module tb_alu_operand_stage;
    logic        clk, rst_n, in_valid, in_ready, in_alu_src, in_reg_write, in_mem_read, flush;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm, exmem_result, memwb_result;
    logic [4:0]  in_rs1, in_rs2, in_rd, exmem_rd, memwb_rd, out_rd;
    logic [3:0]  in_operation, Operation;
    logic        exmem_reg_write, memwb_reg_write, out_valid, out_ready, out_reg_write, out_mem_read;
    logic [31:0] SrcA, SrcB, out_store_data;
    int checks = 0, errors = 0;

    typedef struct {
        logic v;
        logic [31:0] a, b, imm;
        logic [4:0] rs1, rs2, rd;
        logic alu_src;
        logic [3:0] op;
        logic rw, mr;
    } ins_t;
    ins_t m;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_alu_src(in_alu_src),
        .in_operation(in_operation), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .flush(flush), .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
        .exmem_result(exmem_result), .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
        .memwb_result(memwb_result), .out_valid(out_valid), .out_ready(out_ready),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .out_store_data(out_store_data),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string t, logic [31:0] o, logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", t, o, e);
        end
    endtask

    function automatic logic [31:0] fwd(logic [4:0] r, logic [31:0] d);
        if (exmem_reg_write && exmem_rd != 0 && exmem_rd == r) return exmem_result;
        if (memwb_reg_write && memwb_rd != 0 && memwb_rd == r) return memwb_result;
        return d;
    endfunction

    function automatic logic hz();
        return m.v && m.mr && m.rd != 0 && (m.rd == in_rs1 || m.rd == in_rs2);
    endfunction

    function automatic logic rdy();
        return (!m.v || out_ready) && !hz();
    endfunction

    function automatic void model_reset();
        m = '{default: '0};
    endfunction

    task automatic chk_all();
        #2;
        chk("valid", out_valid, m.v);
        chk("in_ready", in_ready, rdy());
        chk("srca", SrcA, fwd(m.rs1, m.a));
        chk("srcb", SrcB, m.alu_src ? m.imm : fwd(m.rs2, m.b));
        chk("op", Operation, m.op);
        chk("store", out_store_data, fwd(m.rs2, m.b));
        chk("rd", out_rd, m.rd);
        chk("reg_write", out_reg_write, m.v && m.rw);
        chk("mem_read", out_mem_read, m.v && m.mr);
    endtask

    task automatic step();
        @(posedge clk);
        if (flush) m.v = 1'b0;
        else if (in_valid && rdy())
            m = '{1'b1, in_rs1_data, in_rs2_data, in_imm, in_rs1, in_rs2, in_rd,
                  in_alu_src, in_operation, in_reg_write, in_mem_read};
        else if (m.v && out_ready) m.v = 1'b0;
        #1;
    endtask

    task automatic put(logic v, logic [4:0] r1, logic [4:0] r2, logic [4:0] d, logic [31:0] a,
                       logic [31:0] b, logic [31:0] im, logic src, logic [3:0] op, logic rw, logic mr);
        in_valid = v; in_rs1 = r1; in_rs2 = r2; in_rd = d; in_rs1_data = a; in_rs2_data = b;
        in_imm = im; in_alu_src = src; in_operation = op; in_reg_write = rw; in_mem_read = mr;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
        memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0;
        put(1, 1, 2, 3, 32'h11, 32'h22, 32'h33, 0, 4'h5, 1, 1);
        model_reset();
        chk_all();
        rst_n = 1'b1;
        step();
        // pass-through with back-to-back acceptance
        put(1, 1, 2, 3, 5, 9, 7, 1, 4'b0010, 1, 0);
        chk_all();
        step();
        put(1, 6, 7, 8, 11, 12, 13, 0, 4'b0011, 1, 0);
        chk_all();
        chk("pt_srca", SrcA, 5);
        chk("pt_srcb", SrcB, 7);
        chk("pt_op", Operation, 2);
        chk("pt_ready", in_ready, 1);
        step();
        in_valid = 0;
        chk_all();
        chk("pt2_op", Operation, 3);
        step();
        // forwarding priority on a held instruction with rs1=rs2=3
        put(1, 3, 3, 9, 32'h1, 32'h2, 32'h3, 0, 4'h1, 1, 0);
        chk_all();
        step();
        in_valid = 0; out_ready = 0;
        exmem_rd = 3; exmem_reg_write = 1; exmem_result = 32'hAA;
        memwb_rd = 3; memwb_reg_write = 1; memwb_result = 32'hBB;
        chk_all();
        chk("fwd_ex", SrcA, 32'hAA);
        exmem_reg_write = 0;
        chk_all();
        chk("fwd_wb", SrcA, 32'hBB);
        exmem_rd = 0; exmem_reg_write = 1;
        chk_all();
        chk("fwd_x0", SrcA, 32'hBB);
        step();
        exmem_reg_write = 0; memwb_reg_write = 0; out_ready = 1;
        chk_all();
        chk("fwd_none", SrcA, 32'h1);
        step();
        // load-use stall and bubble
        put(1, 1, 2, 4, 32'h10, 32'h20, 0, 0, 4'h0, 1, 1);
        chk_all();
        step();
        put(1, 6, 4, 10, 32'h30, 32'h40, 0, 0, 4'h4, 1, 0);
        chk_all();
        chk("lu_ready", in_ready, 0);
        step();
        chk_all();
        chk("lu_bubble", out_valid, 0);
        step();
        chk_all();
        chk("lu_cap_op", Operation, 4);
        put(1, 1, 2, 0, 32'h50, 32'h60, 0, 0, 4'h0, 1, 1);
        step();
        put(1, 0, 0, 11, 32'h70, 32'h80, 0, 0, 4'h6, 1, 0);
        chk_all();
        chk("x0_ready", in_ready, 1);
        step();
        // back-pressure hold then simultaneous release and capture
        put(1, 8, 9, 12, 32'h90, 32'hA0, 32'hB0, 1, 4'h7, 1, 0);
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            chk_all();
            chk("bp_ready", in_ready, 0);
            chk("bp_op", Operation, 6);
            step();
        end
        out_ready = 1;
        chk_all();
        chk("bp_release", in_ready, 1);
        step();
        chk_all();
        chk("bp_next_op", Operation, 7);
        // flush discards incoming
        put(1, 1, 2, 13, 1, 2, 3, 0, 4'h9, 1, 0);
        flush = 1;
        chk_all();
        chk("fl_ready", in_ready, 1);
        step();
        flush = 0; in_valid = 0;
        chk_all();
        chk("fl_valid", out_valid, 0);
        chk("fl_rw", out_reg_write, 0);
        step();
        // asynchronous reset with an instruction held
        put(1, 1, 2, 14, 32'hC0, 32'hD0, 32'hE0, 1, 4'hA, 1, 0);
        chk_all();
        step();
        in_valid = 0;
        #2;
        rst_n = 0;
        model_reset();
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_op", Operation, 0);
        chk("rst_srca", SrcA, 0);
        chk("rst_srcb", SrcB, 0);
        chk_all();
        rst_n = 1;
        step();
        // random traffic
        for (int i = 0; i < 400; i++) begin
            put($urandom_range(0, 1), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 1'($urandom),
                4'($urandom), 1'($urandom), 1'($urandom));
            out_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 15) == 0;
            exmem_rd = 5'($urandom_range(0, 7)); exmem_reg_write = 1'($urandom); exmem_result = $urandom;
            memwb_rd = 5'($urandom_range(0, 7)); memwb_reg_write = 1'($urandom); memwb_result = $urandom;
            chk_all();
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline register that directly feeds the ALU.
- Captures decoded operands and control, resolves forwarding from the EX/MEM and MEM/WB stages, and selects immediates.
- Drives SrcA, SrcB and Operation to the ALU.
- Detects load-use hazards and back-pressures decode.
- Single-entry buffer with a valid/ready handshake on both sides, plus a flush for taken branches.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- OPCODE_LENGTH, 4, ALU Operation width.
- REG_ADDR_W, 5, register index width.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  decode presents an instruction
in_ready  output  1  stage accepts the instruction this cycle
in_rs1_data  input  DATA_WIDTH  register-file read 1
in_rs2_data  input  DATA_WIDTH  register-file read 2
in_imm  input  DATA_WIDTH  sign-extended immediate
in_rs1  input  REG_ADDR_W  source 1 index
in_rs2  input  REG_ADDR_W  source 2 index
in_rd  input  REG_ADDR_W  destination index
in_alu_src  input  1  1: SrcB = imm, 0: SrcB = rs2
in_operation  input  OPCODE_LENGTH  ALU opcode
in_reg_write  input  1  writes rd
in_mem_read  input  1  load instruction
flush  input  1  discard held and incoming instruction
exmem_rd  input  REG_ADDR_W  EX/MEM destination
exmem_reg_write  input  1  EX/MEM writes rd
exmem_result  input  DATA_WIDTH  EX/MEM ALU result
memwb_rd  input  REG_ADDR_W  MEM/WB destination
memwb_reg_write  input  1  MEM/WB writes rd
memwb_result  input  DATA_WIDTH  MEM/WB writeback value
out_valid  output  1  held instruction valid
out_ready  input  1  EX/MEM accepts this cycle
SrcA  output  DATA_WIDTH  ALU operand A
SrcB  output  DATA_WIDTH  ALU operand B
Operation  output  OPCODE_LENGTH  ALU opcode
out_store_data  output  DATA_WIDTH  forwarded rs2 for stores
out_rd  output  REG_ADDR_W  held destination
out_reg_write  output  1  held write enable, gated by out_valid
out_mem_read  output  1  held load flag, gated by out_valid

Behaviour:

Reset:
- rst_n low asynchronously clears every register: out_valid=0 and all held fields 0.
- Consequently Operation=4'b0000, SrcA=SrcB=out_store_data=0 (no forwarding matches rd 0), out_rd=0, out_reg_write=0, out_mem_read=0.
- Reset mid-handshake drops the held instruction. No instruction survives reset.

Load-use hazard:
- hazard = out_valid & out_mem_read & (out_rd!=0) & ((out_rd==in_rs1) | (out_rd==in_rs2)).

Ready:
- in_ready = (!out_valid | out_ready) & !hazard.

Register update, priority in this order:
1. flush: out_valid<=0; incoming is discarded even if in_valid & in_ready.
2. in_valid & in_ready: load all in_* fields, out_valid<=1.
3. out_valid & out_ready and no capture: out_valid<=0. This is the bubble inserted on a load-use stall, or a plain drain.
4. Otherwise hold all fields.

Latency and throughput:
- One cycle from capture to presentation on the ALU ports.
- Full throughput: capture and release may occur in the same cycle.
- No combinational path from in_* to SrcA/SrcB. in_ready depends combinationally on out_ready and on in_rs1/in_rs2.

Forwarding (combinational on held fields):
- fwdA = exmem_result if exmem_reg_write & exmem_rd!=0 & exmem_rd==held_rs1.
- Else fwdA = memwb_result if memwb_reg_write & memwb_rd!=0 & memwb_rd==held_rs1.
- Else fwdA = held_rs1_data.
- EX/MEM has priority over MEM/WB. x0 is never forwarded. fwdB is computed identically on held_rs2.

Operand selection:
- SrcA = fwdA.
- SrcB = held_alu_src ? held_imm : fwdB.
- out_store_data = fwdB, regardless of alu_src.
- Operation = held_operation.
- When out_valid=0, the ALU ports still show held values, but out_reg_write and out_mem_read are forced to 0.

Test Plan:
1. Reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0, Operation=0, SrcA=SrcB=0 immediately, without waiting for clk.
2. Pass-through: capture rs1_data=5, imm=7, alu_src=1, op=4'b0010, out_ready=1 -> next cycle SrcA=5, SrcB=7, Operation=2, out_valid=1. A back-to-back second instruction is accepted with in_ready=1 every cycle.
3. Forwarding priority: held rs1=3; exmem_rd=3 writing 0xAA and memwb_rd=3 writing 0xBB -> SrcA=0xAA. Drop exmem_reg_write -> SrcA=0xBB. Set exmem_rd=0 with write enabled -> SrcA falls back to MEM/WB or rs1_data.
4. Load-use: held load rd=4; decode presents in_rs2=4 -> in_ready=0. The held load is released, the next cycle has out_valid=0 (bubble), then the instruction is captured. A hazard on rd=0 causes no stall.
5. Back-pressure: out_ready=0 with out_valid=1 -> in_ready=0 and outputs hold stable for 3 cycles. Raising out_ready releases the held instruction and captures the next one in the same cycle.
6. Flush: flush=1 with in_valid=1 and in_ready=1 -> next cycle out_valid=0, out_reg_write=0, and the incoming instruction never appears.
